multi_seq_detector: RTL and testbench

//  Parametrised successor to the single fixed-length programmable sequence detector.

---
 rtl/multi_seq_detector_pkg.sv | 22 ++
 rtl/multi_seq_detector_if.sv | 34 +++
 rtl/multi_seq_detector_lane.sv | 92 +++++++++
 rtl/multi_seq_detector.sv | 90 +++++++++
 tb/tb_multi_seq_detector.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_seq_detector_pkg.sv
// Shared types and helpers for the multi-lane sequence detector.
package multi_seq_det_pkg;

   // Largest pattern length any lane may be built with; the fill counter is
   // sized so it can hold this value.
   localparam int unsigned PAT_W_MAX = 32;
   localparam int unsigned FILL_W    = $clog2(PAT_W_MAX + 1);

   typedef logic [FILL_W-1:0] fill_t;

   // Effective pattern length: position of the highest care bit plus one.
   // An all-zero mask yields 0, which disables the lane.
   function automatic fill_t msb_len(input logic [PAT_W_MAX-1:0] mask);
      fill_t len;
      len = '0;
      for (int i = 0; i < PAT_W_MAX; i++) begin
         len = mask[i] ? fill_t'(i + 1) : len;
      end
      return len;
   endfunction

endpackage

// File: rtl/multi_seq_detector_if.sv
// Configuration, stream and status signals of the multi-lane sequence detector.
interface multi_seq_detector_if #(
   parameter int PAT_W   = 8,
   parameter int NUM_PAT = 2,
   parameter int CNT_W   = 8
);
   localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

   logic               cfg_we;
   logic [IDX_W-1:0]   cfg_idx;
   logic [PAT_W-1:0]   cfg_pattern;
   logic [PAT_W-1:0]   cfg_mask;
   logic               cfg_overlap;
   logic               din_valid;
   logic               din;
   logic               cnt_clr;
   logic [NUM_PAT-1:0] seen;
   logic               seen_any;
   logic [CNT_W-1:0]   match_cnt;

   // Stimulus / configuration side.
   modport master (
      output cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_overlap,
      output din_valid, din, cnt_clr,
      input  seen, seen_any, match_cnt
   );

   // Detector side.
   modport slave (
      input  cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_overlap,
      input  din_valid, din, cnt_clr,
      output seen, seen_any, match_cnt
   );
endinterface

// File: rtl/multi_seq_detector_lane.sv
// One pattern lane: holds its pattern and care mask, counts fresh beats and
// compares against the shared post-shift history.
module seq_match_lane
   import multi_seq_det_pkg::*;
#(
   parameter int PAT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cfg_we_i,
   input  logic [PAT_W-1:0] cfg_pattern_i,
   input  logic [PAT_W-1:0] cfg_mask_i,
   input  logic             overlap_i,
   input  logic             beat_i,
   input  logic [PAT_W-1:0] hist_i,
   output logic             match_o,
   output logic             seen_o
);
   localparam fill_t FILL_MAX = fill_t'(PAT_W);

   logic [PAT_W-1:0]     pat_q;
   logic [PAT_W-1:0]     mask_q;
   fill_t                fill_q;
   fill_t                fill_d;
   fill_t                fill_inc_s;
   fill_t                len_s;
   logic [PAT_W_MAX-1:0] mask_ext_s;
   logic                 match_s;
   logic                 seen_q;

   // Lane length derived from the highest care bit.
   always_comb begin
      mask_ext_s              = '0;
      mask_ext_s[PAT_W-1:0]   = mask_q;
      len_s                   = msb_len(mask_ext_s);
   end

   // Fill count after the current beat, saturating at the pattern width.
   always_comb begin
      if (fill_q == FILL_MAX) begin
         fill_inc_s = fill_q;
      end else begin
         fill_inc_s = fill_q + fill_t'(1);
      end
   end

   // Match needs enough fresh bits so a zeroed/stale history can't fake a hit;
   // a config write on the same beat suppresses it.
   always_comb begin
      match_s = beat_i && !cfg_we_i && (mask_q != '0) &&
                (((hist_i ^ pat_q) & mask_q) == '0) && (fill_inc_s >= len_s);
   end

   // Fill counter: restarts on config write, or on a match in non-overlap mode.
   always_comb begin
      if (cfg_we_i) begin
         fill_d = '0;
      end else if (beat_i) begin
         if (match_s && !overlap_i) begin
            fill_d = '0;
         end else begin
            fill_d = fill_inc_s;
         end
      end else begin
         fill_d = fill_q;
      end
   end

   // Lane state registers and registered match pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pat_q  <= '0;
         mask_q <= '0;
         fill_q <= '0;
         seen_q <= 1'b0;
      end else begin
         if (cfg_we_i) begin
            pat_q  <= cfg_pattern_i;
            mask_q <= cfg_mask_i;
         end else begin
            pat_q  <= pat_q;
            mask_q <= mask_q;
         end
         fill_q <= fill_d;
         seen_q <= match_s;
      end
   end

   assign match_o = match_s;
   assign seen_o  = seen_q;

endmodule

// File: rtl/multi_seq_detector.sv
// Multi-lane programmable serial sequence detector: shared history shift
// register, per-lane matchers, combined pulse and saturating match counter.
module multi_seq_detector
   import multi_seq_det_pkg::*;
#(
   parameter int PAT_W   = 8,
   parameter int NUM_PAT = 2,
   parameter int CNT_W   = 8
) (
   input logic                clk,
   input logic                resetn,
   multi_seq_detector_if.slave bus
);
   localparam int               IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_W-1:0]   hist_q;
   logic [PAT_W-1:0]   hist_d;
   logic [NUM_PAT-1:0] lane_we_s;
   logic [NUM_PAT-1:0] match_s;
   logic [NUM_PAT-1:0] seen_s;
   logic               seen_any_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   // Post-shift history: newest bit enters at bit 0, frozen on idle cycles.
   always_comb begin
      if (bus.din_valid) begin
         hist_d = {hist_q[PAT_W-2:0], bus.din};
      end else begin
         hist_d = hist_q;
      end
   end

   // Shared history register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_lane
      // Out-of-range indices select no lane, so such writes are dropped.
      assign lane_we_s[gi] = bus.cfg_we && (bus.cfg_idx == IDX_W'(gi));

      seq_match_lane #(
         .PAT_W (PAT_W)
      ) u_lane (
         .clk           (clk),
         .resetn        (resetn),
         .cfg_we_i      (lane_we_s[gi]),
         .cfg_pattern_i (bus.cfg_pattern),
         .cfg_mask_i    (bus.cfg_mask),
         .overlap_i     (bus.cfg_overlap),
         .beat_i        (bus.din_valid),
         .hist_i        (hist_d),
         .match_o       (match_s[gi]),
         .seen_o        (seen_s[gi])
      );
   end

   // Counter next value: clear wins, otherwise +1 per matching cycle, saturating.
   always_comb begin
      if (bus.cnt_clr) begin
         cnt_d = '0;
      end else if ((|match_s) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Match counter and combined pulse, aligned with the per-lane seen flops.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q      <= '0;
         seen_any_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         seen_any_q <= |match_s;
      end
   end

   assign bus.seen      = seen_s;
   assign bus.seen_any  = seen_any_q;
   assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_multi_seq_detector.sv
// Bench for multi_seq_detector: directed table, hand sequences, random vs model.
module tb_multi_seq_detector;
   localparam int PAT_W   = 8;
   localparam int NUM_PAT = 2;
   localparam int CNT_W   = 4;

   logic clk;
   logic resetn;

   multi_seq_detector_if #(.PAT_W(PAT_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) bus ();

   multi_seq_detector #(.PAT_W(PAT_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string    name;
      bit       rst;
      bit       we;
      bit       idx;
      bit [7:0] pat;
      bit [7:0] mask;
      bit       ovl;
      bit       vld;
      bit       d;
      bit       clr;
      bit [1:0] e_seen;
      bit [3:0] e_cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_vec;
   int   n_bad;

   // Reference model: bit history as a list, per-lane count of fresh beats.
   bit       m_bits[$];
   bit [7:0] m_pat[2];
   bit [7:0] m_mask[2];
   int       m_fresh[2];
   int       m_cnt;
   bit [1:0] m_seen;

   function automatic int len_of(input bit [7:0] m);
      int l = 0;
      for (int j = 0; j < 8; j++) if (m[j]) l = j + 1;
      return l;
   endfunction

   function automatic void model_step(input vec_t v);
      m_seen = 2'b00;
      if (v.rst) begin
         m_bits.delete();
         for (int i = 0; i < 2; i++) begin
            m_pat[i] = 8'h00; m_mask[i] = 8'h00; m_fresh[i] = 0;
         end
         m_cnt = 0;
         return;
      end
      if (v.vld) begin
         m_bits.push_front(v.d);
         if (m_bits.size() > 16) void'(m_bits.pop_back());
      end
      for (int i = 0; i < 2; i++) begin
         if (v.we && (int'(v.idx) == i)) begin
            m_pat[i] = v.pat; m_mask[i] = v.mask; m_fresh[i] = 0;
         end else if (v.vld) begin
            bit ok;
            int l;
            m_fresh[i]++;
            l  = len_of(m_mask[i]);
            ok = (l > 0) && (m_fresh[i] >= l);
            for (int j = 0; j < l; j++)
               if (ok && m_mask[i][j] && (m_bits[j] != m_pat[i][j])) ok = 1'b0;
            if (ok) begin
               m_seen[i] = 1'b1;
               if (!v.ovl) m_fresh[i] = 0;
            end
         end
      end
      if (v.clr) m_cnt = 0;
      else if ((m_seen != 2'b00) && (m_cnt < 15)) m_cnt++;
   endfunction

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(input string nm, input bit rst, input bit we, input bit idx,
                               input bit [7:0] pat, input bit [7:0] mask, input bit ovl,
                               input bit vld, input bit d, input bit clr,
                               input bit [1:0] es, input bit [3:0] ec);
      vec_t v;
      v.name = nm; v.rst = rst; v.we = we; v.idx = idx; v.pat = pat; v.mask = mask;
      v.ovl = ovl; v.vld = vld; v.d = d; v.clr = clr; v.e_seen = es; v.e_cnt = ec;
      return v;
   endfunction

   function automatic vec_t v_rst(input string nm);
      return mk(nm, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
   endfunction

   function automatic vec_t v_cfg(input string nm, input bit idx, input bit [7:0] pat,
                                  input bit [7:0] mask, input bit ovl, input bit [3:0] ec);
      return mk(nm, 1'b0, 1'b1, idx, pat, mask, ovl, 1'b0, 1'b0, 1'b0, 2'b00, ec);
   endfunction

   function automatic vec_t v_beat(input string nm, input bit d, input bit ovl,
                                   input bit [1:0] es, input bit [3:0] ec);
      return mk(nm, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ovl, 1'b1, d, 1'b0, es, ec);
   endfunction

   function automatic vec_t v_idle(input string nm, input bit [3:0] ec);
      return mk(nm, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, ec);
   endfunction

   // Drive one cycle, advance the model, and compare after the edge.
   task automatic apply(input vec_t v, input bit use_model);
      bit [1:0] es;
      bit [3:0] ec;
      resetn          = !v.rst;
      bus.cfg_we      = v.we;
      bus.cfg_idx     = v.idx;
      bus.cfg_pattern = v.pat;
      bus.cfg_mask    = v.mask;
      bus.cfg_overlap = v.ovl;
      bus.din_valid   = v.vld;
      bus.din         = v.d;
      bus.cnt_clr     = v.clr;
      @(posedge clk);
      model_step(v);
      #1;
      n_vec++;
      es = use_model ? m_seen : v.e_seen;
      ec = use_model ? 4'(m_cnt) : v.e_cnt;
      check({v.name, ".seen"},      32'(bus.seen),      32'(es));
      check({v.name, ".seen_any"},  32'(bus.seen_any),  32'(|es));
      check({v.name, ".match_cnt"}, 32'(bus.match_cnt), 32'(ec));
   endtask

   initial begin
      bit       s1[8];
      bit       e1[8];
      bit [3:0] c1[8];
      bit       e2[8];
      bit [3:0] c2[8];
      bit       ovl;
      vec_t     rv;

      n_vec = 0;
      n_bad = 0;

      // ---- directed table: tests 1-4 ----
      s1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      e1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      c1 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
      e2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      c2 = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};

      tbl.push_back(v_rst("reset"));
      tbl.push_back(v_cfg("t1_cfg_ovl", 1'b0, 8'h16, 8'h1F, 1'b1, 4'd0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(v_beat($sformatf("t1_ovl_b%0d", k + 1), s1[k], 1'b1, {1'b0, e1[k]}, c1[k]));
      tbl.push_back(v_cfg("t1_cfg_novl", 1'b0, 8'h16, 8'h1F, 1'b0, 4'd2));
      for (int k = 0; k < 8; k++)
         tbl.push_back(v_beat($sformatf("t1_novl_b%0d", k + 1), s1[k], 1'b0, {1'b0, e2[k]}, c2[k]));

      tbl.push_back(v_rst("t2_reset"));
      tbl.push_back(v_cfg("t2_cfg", 1'b0, 8'h00, 8'h07, 1'b1, 4'd0));
      tbl.push_back(v_beat("t2_b1", 1'b0, 1'b1, 2'b00, 4'd0));
      tbl.push_back(v_beat("t2_b2", 1'b0, 1'b1, 2'b00, 4'd0));
      tbl.push_back(v_beat("t2_b3", 1'b0, 1'b1, 2'b01, 4'd1));

      tbl.push_back(v_cfg("t3_cfg", 1'b0, 8'h05, 8'h07, 1'b1, 4'd1));
      tbl.push_back(v_beat("t3_b1", 1'b1, 1'b1, 2'b00, 4'd1));
      tbl.push_back(v_idle("t3_i1", 4'd1));
      tbl.push_back(v_idle("t3_i2", 4'd1));
      tbl.push_back(v_beat("t3_b2", 1'b0, 1'b1, 2'b00, 4'd1));
      tbl.push_back(v_idle("t3_i3", 4'd1));
      tbl.push_back(v_idle("t3_i4", 4'd1));
      tbl.push_back(v_beat("t3_b3", 1'b1, 1'b1, 2'b01, 4'd2));
      tbl.push_back(v_idle("t3_i5", 4'd2));

      tbl.push_back(v_cfg("t4_cfg0", 1'b0, 8'h05, 8'h05, 1'b1, 4'd2));
      tbl.push_back(v_beat("t4_b1", 1'b1, 1'b1, 2'b00, 4'd2));
      tbl.push_back(v_beat("t4_b2", 1'b1, 1'b1, 2'b00, 4'd2));
      tbl.push_back(v_beat("t4_b3", 1'b1, 1'b1, 2'b01, 4'd3));
      tbl.push_back(v_beat("t4_b4", 1'b1, 1'b1, 2'b01, 4'd4));
      tbl.push_back(v_cfg("t4_cfg1", 1'b1, 8'h03, 8'h03, 1'b1, 4'd4));
      tbl.push_back(v_beat("t4_both1", 1'b1, 1'b1, 2'b01, 4'd5));
      tbl.push_back(v_beat("t4_both2", 1'b1, 1'b1, 2'b11, 4'd6));
      tbl.push_back(v_beat("t4_both3", 1'b1, 1'b1, 2'b11, 4'd7));

      foreach (tbl[k]) apply(tbl[k], 1'b0);

      // ---- test 5: config write on the completing beat ----
      apply(v_rst("t5_reset"), 1'b0);
      apply(v_cfg("t5_cfg0", 1'b0, 8'h05, 8'h07, 1'b1, 4'd0), 1'b0);
      apply(v_cfg("t5_cfg1", 1'b1, 8'h01, 8'h01, 1'b1, 4'd0), 1'b0);
      apply(v_beat("t5_b1", 1'b1, 1'b1, 2'b10, 4'd1), 1'b0);
      apply(v_beat("t5_b2", 1'b0, 1'b1, 2'b00, 4'd1), 1'b0);
      apply(mk("t5_we_beat", 1'b0, 1'b1, 1'b0, 8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 4'd2), 1'b0);
      apply(v_beat("t5_b4", 1'b0, 1'b1, 2'b00, 4'd2), 1'b0);
      apply(v_beat("t5_b5_short", 1'b1, 1'b1, 2'b10, 4'd3), 1'b0);
      apply(v_beat("t5_b6", 1'b0, 1'b1, 2'b00, 4'd3), 1'b0);
      apply(v_beat("t5_b7_full", 1'b1, 1'b1, 2'b11, 4'd4), 1'b0);

      // ---- test 6: saturation, clear priority, reset mid-stream ----
      apply(v_rst("t6_reset"), 1'b0);
      apply(v_cfg("t6_cfg1", 1'b1, 8'h01, 8'h01, 1'b1, 4'd0), 1'b0);
      for (int k = 1; k <= 20; k++)
         apply(v_beat($sformatf("t6_sat%0d", k), 1'b1, 1'b1, 2'b10, (k > 15) ? 4'd15 : 4'(k)), 1'b0);
      apply(mk("t6_clr_match", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 4'd0), 1'b0);
      apply(v_beat("t6_after_clr", 1'b1, 1'b1, 2'b10, 4'd1), 1'b0);
      apply(mk("t6_mid_reset", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0), 1'b0);
      for (int k = 1; k <= 3; k++)
         apply(v_beat($sformatf("t6_disabled%0d", k), 1'b1, 1'b1, 2'b00, 4'd0), 1'b0);

      // ---- randomized stimulus against the model ----
      apply(v_rst("rnd_reset"), 1'b1);
      ovl = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 49) == 0) ovl = ~ovl;
         rv = mk("rnd",
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 8'($urandom) & (8'hFF >> $urandom_range(2, 7)),
                 ovl,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0,
                 2'b00, 4'd0);
         apply(rv, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
